winograd_output_collector: RTL and testbench

Consumer end of the Winograd F(2x2,3x3) pipeline. Accepts 2x2 output tiles (Y) produced by the output transform, one tile per handshake, in raster tile order. Reassembles them into a row-major output pixel stream, with end-of-row and end-of-frame markers. Two ping-pong tile-row banks let the next tile row fill while the previous one drains.

---
 rtl/winograd_pkg.sv | 20 ++
 rtl/winograd_tile_row_bank.sv | 50 +++++
 rtl/winograd_output_collector.sv | 146 ++++++++++++++
 tb/tb_winograd_output_collector.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// Shared constants for the Winograd F(2x2,3x3) pipeline: element width and Y tile lane offsets.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package winograd_pkg;

  // Default width of one output element (one Y lane)
  localparam int W = 16;

  // Lane offsets into a packed 2x2 Y tile, in units of W bits (row, col)
  localparam int Y00 = 0;
  localparam int Y01 = 1;
  localparam int Y10 = 2;
  localparam int Y11 = 3;

  // Index width for a counter over n values, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/winograd_tile_row_bank.sv
// One tile-row buffer: 2 x IMG_W element registers, written a 2x2 tile at a time, read one pixel at a time.
// Latency: write visible on the read port the cycle after wr_en; read port is combinational.
// Backpressure: none; the owner decides when writing is allowed.
module winograd_tile_row_bank #(
  parameter int W     = winograd_pkg::W,
  parameter int IMG_W = 4,
  parameter int TC_W  = winograd_pkg::idx_w(IMG_W / 2),
  parameter int COL_W = winograd_pkg::idx_w(IMG_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [TC_W-1:0]  wr_tcol,
  input  logic [2*W-1:0]   wr_top,
  input  logic [2*W-1:0]   wr_bot,
  input  logic             rd_row,
  input  logic [COL_W-1:0] rd_col,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0]     top_q [IMG_W];
  logic [W-1:0]     bot_q [IMG_W];
  logic [COL_W-1:0] col_even;
  logic [COL_W-1:0] col_odd;

  // A tile column covers pixel columns 2*tcol and 2*tcol+1
  assign col_even = COL_W'({wr_tcol, 1'b0});
  assign col_odd  = COL_W'({wr_tcol, 1'b1});

  // Store the tile's top lane pair and bottom lane pair; reset clears all elements
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IMG_W; i++) begin
        top_q[i] <= '0;
        bot_q[i] <= '0;
      end
    end else if (wr_en) begin
      top_q[col_even] <= wr_top[W-1:0];
      top_q[col_odd]  <= wr_top[2*W-1:W];
      bot_q[col_even] <= wr_bot[W-1:0];
      bot_q[col_odd]  <= wr_bot[2*W-1:W];
    end
  end

  // Single combinational read port
  always_comb begin
    rd_data = rd_row ? bot_q[rd_col] : top_q[rd_col];
  end

endmodule

// File: rtl/winograd_output_collector.sv
// Reassembles raster-order 2x2 Y tiles into a row-major pixel stream with eol/eof, via two ping-pong tile-row banks.
// Latency: px_valid rises the cycle after the last tile of a tile row is accepted; 1 pixel/cycle thereafter.
// Backpressure: px_ready low holds the current pixel; y_ready drops only while the bank being filled is still full.
module winograd_output_collector #(
  parameter int W     = winograd_pkg::W,
  parameter int IMG_W = 4,
  parameter int IMG_H = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         y_valid,
  output logic         y_ready,
  input  logic [4*W-1:0] y_data,
  output logic         px_valid,
  input  logic         px_ready,
  output logic [W-1:0] px_data,
  output logic         px_eol,
  output logic         px_eof
);
  import winograd_pkg::*;

  localparam int TC_W  = idx_w(IMG_W / 2);
  localparam int COL_W = idx_w(IMG_W);
  localparam int TR_W  = idx_w(IMG_H / 2);

  localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(IMG_W / 2 - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [TR_W-1:0]  TR_LAST  = TR_W'(IMG_H / 2 - 1);

  logic             wr_bank;
  logic [TC_W-1:0]  wr_tcol;
  logic             rd_bank;
  logic             rd_row;
  logic [COL_W-1:0] rd_col;
  logic [TR_W-1:0]  rd_trow;
  logic [1:0]       full;

  logic             y_fire;
  logic             px_fire;
  logic             wr_last;
  logic             rd_last;
  logic [1:0]       set_full;
  logic [1:0]       clr_full;
  logic [2*W-1:0]   wr_top;
  logic [2*W-1:0]   wr_bot;
  logic [W-1:0]     bank_data [2];

  // Handshakes and end-of-tile-row detection on both sides
  always_comb begin
    y_ready  = !full[wr_bank] && !rst;
    y_fire   = y_valid && y_ready;
    px_valid = full[rd_bank];
    px_fire  = px_valid && px_ready;
    wr_last  = (wr_tcol == TC_LAST);
    rd_last  = rd_row && (rd_col == COL_LAST);
    for (int b = 0; b < 2; b++) begin
      set_full[b] = y_fire && wr_last && (wr_bank == 1'(b));
      clr_full[b] = px_fire && rd_last && (rd_bank == 1'(b));
    end
  end

  // Split the packed tile into its top and bottom lane pairs
  always_comb begin
    wr_top = {y_data[Y01*W +: W], y_data[Y00*W +: W]};
    wr_bot = {y_data[Y11*W +: W], y_data[Y10*W +: W]};
  end

  // Ping-pong banks, each written only while it is the current write bank
  for (genvar b = 0; b < 2; b++) begin : g_bank
    winograd_tile_row_bank #(
      .W     (W),
      .IMG_W (IMG_W),
      .TC_W  (TC_W),
      .COL_W (COL_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (y_fire && (wr_bank == 1'(b))),
      .wr_tcol (wr_tcol),
      .wr_top  (wr_top),
      .wr_bot  (wr_bot),
      .rd_row  (rd_row),
      .rd_col  (rd_col),
      .rd_data (bank_data[b])
    );
  end

  // Output mux and row/frame markers, all from registered state so they hold during stalls
  always_comb begin
    px_data = bank_data[rd_bank];
    px_eol  = px_valid && (rd_col == COL_LAST);
    px_eof  = px_eol && rd_row && (rd_trow == TR_LAST);
  end

  // Write-side tile column and bank counters
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_tcol <= '0;
    end else if (y_fire) begin
      if (wr_last) begin
        wr_tcol <= '0;
        wr_bank <= !wr_bank;
      end else begin
        wr_tcol <= wr_tcol + 1'b1;
      end
    end
  end

  // Read-side column, row, tile-row and bank counters
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank <= 1'b0;
      rd_row  <= 1'b0;
      rd_col  <= '0;
      rd_trow <= '0;
    end else if (px_fire) begin
      if (rd_col == COL_LAST) begin
        rd_col <= '0;
        rd_row <= !rd_row;
        if (rd_row) begin
          rd_bank <= !rd_bank;
          rd_trow <= (rd_trow == TR_LAST) ? '0 : rd_trow + 1'b1;
        end
      end else begin
        rd_col <= rd_col + 1'b1;
      end
    end
  end

  // Full flags: set and clear in the same cycle always hit different banks
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (set_full[b]) begin
          full[b] <= 1'b1;
        end else if (clr_full[b]) begin
          full[b] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_winograd_output_collector.sv
// Directed bench for winograd_output_collector: tile-to-pixel ordering, markers, latency, backpressure, reset.
// Latency: n/a.
// Backpressure: px_ready driven per scenario (constant or random).
module tb_winograd_output_collector;
  localparam int W     = 16;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           y_valid;
  logic           y_ready;
  logic [4*W-1:0] y_data;
  logic           px_valid;
  logic           px_ready;
  logic [W-1:0]   px_data;
  logic           px_eol;
  logic           px_eof;

  always #5 clk = ~clk;

  winograd_output_collector #(.W(W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk      (clk),
    .rst      (rst),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_data   (y_data),
    .px_valid (px_valid),
    .px_ready (px_ready),
    .px_data  (px_data),
    .px_eol   (px_eol),
    .px_eof   (px_eof)
  );

  int vec  = 0;
  int errs = 0;
  int cyc  = 0;

  logic [4*W-1:0] tile_q [$];
  int             acc_count;
  int             acc_cyc [$];
  logic [W-1:0]   cap_dat [$];
  bit             cap_eol [$];
  bit             cap_eof [$];
  int             cap_cyc [$];
  bit             ready_en;
  bit             rnd_ready;

  logic           s_valid, s_pxr, s_eol, s_eof, s_yrdy;
  logic [W-1:0]   s_dat;
  int             s_cyc;

  function automatic logic [4*W-1:0] tile(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  task automatic push_frame(input int base);
    tile_q.push_back(tile(base+1,  base+2,  base+5,  base+6));
    tile_q.push_back(tile(base+3,  base+4,  base+7,  base+8));
    tile_q.push_back(tile(base+9,  base+10, base+13, base+14));
    tile_q.push_back(tile(base+11, base+12, base+15, base+16));
  endtask

  task automatic drive_inputs();
    y_valid  = (tile_q.size() > 0);
    y_data   = y_valid ? tile_q[0] : '0;
    px_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : ready_en;
  endtask

  // One clock: sample at negedge, account handshakes, then drive new inputs 1 after posedge
  task automatic cycle();
    @(negedge clk);
    s_cyc   = cyc;
    s_valid = px_valid;
    s_pxr   = px_ready;
    s_dat   = px_data;
    s_eol   = px_eol;
    s_eof   = px_eof;
    s_yrdy  = y_ready;
    if (!rst && px_valid && px_ready) begin
      cap_dat.push_back(px_data);
      cap_eol.push_back(px_eol);
      cap_eof.push_back(px_eof);
      cap_cyc.push_back(cyc);
    end
    if (!rst && y_valid && y_ready) begin
      void'(tile_q.pop_front());
      acc_count++;
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_inputs();
  endtask

  task automatic clear_capture();
    cap_dat.delete();
    cap_eol.delete();
    cap_eof.delete();
    cap_cyc.delete();
    acc_cyc.delete();
    acc_count = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tile_q.delete();
    rnd_ready = 1'b0;
    ready_en  = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    clear_capture();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tile_q.delete();
    ready_en = 1'b1;
    cycle();
    cycle();
    vec++; if (s_yrdy !== 1'b0) begin errs++; $display("FAIL reset_y_ready: got %0b want 0", s_yrdy); end
    vec++; if (s_valid !== 1'b0) begin errs++; $display("FAIL reset_px_valid: got %0b want 0", s_valid); end
    vec++; if (s_eol !== 1'b0) begin errs++; $display("FAIL reset_px_eol: got %0b want 0", s_eol); end
    vec++; if (s_eof !== 1'b0) begin errs++; $display("FAIL reset_px_eof: got %0b want 0", s_eof); end
    vec++; if (s_dat !== '0) begin errs++; $display("FAIL reset_px_data: got %0d want 0", s_dat); end
    rst = 1'b0;
    cycle();
    vec++; if (s_yrdy !== 1'b1) begin errs++; $display("FAIL post_reset_y_ready: got %0b want 1", s_yrdy); end
    vec++; if (s_valid !== 1'b0) begin errs++; $display("FAIL post_reset_px_valid: got %0b want 0", s_valid); end
  endtask

  task automatic test_single_row();
    int first_valid;
    do_reset();
    ready_en = 1'b1;
    tile_q.push_back(tile(1, 2, 5, 6));
    tile_q.push_back(tile(3, 4, 7, 8));
    drive_inputs();
    first_valid = -1;
    for (int i = 0; i < 40 && cap_dat.size() < 8; i++) begin
      cycle();
      if (s_valid && first_valid < 0) first_valid = s_cyc;
    end
    vec++;
    if (cap_dat.size() != 8 || acc_cyc.size() < 2) begin
      errs++; $display("FAIL row_count: got %0d pixels want 8", cap_dat.size());
    end else begin
      vec++;
      if (first_valid != acc_cyc[1] + 1) begin
        errs++; $display("FAIL row_latency: px_valid at cycle %0d want %0d", first_valid, acc_cyc[1] + 1);
      end
      for (int i = 0; i < 8; i++) begin
        vec++;
        if (cap_dat[i] !== W'(i + 1) || cap_eol[i] !== (i == 3 || i == 7) || cap_eof[i] !== 1'b0) begin
          errs++; $display("FAIL row_pixel[%0d]: got %0d eol %0b eof %0b want %0d eol %0b eof 0",
                           i, cap_dat[i], cap_eol[i], cap_eof[i], i + 1, (i == 3 || i == 7));
        end
      end
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    ready_en = 1'b1;
    push_frame(0);
    drive_inputs();
    for (int i = 0; i < 60 && cap_dat.size() < 16; i++) cycle();
    vec++;
    if (cap_dat.size() != 16) begin
      errs++; $display("FAIL frame_count: got %0d pixels want 16", cap_dat.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        vec++;
        if (cap_dat[i] !== W'(i + 1) || cap_eol[i] !== (i % 4 == 3) || cap_eof[i] !== (i == 15)) begin
          errs++; $display("FAIL frame_pixel[%0d]: got %0d eol %0b eof %0b want %0d eol %0b eof %0b",
                           i, cap_dat[i], cap_eol[i], cap_eof[i], i + 1, (i % 4 == 3), (i == 15));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_en = 1'b0;
    push_frame(0);
    tile_q.push_back(tile(17, 18, 21, 22));
    tile_q.push_back(tile(19, 20, 23, 24));
    drive_inputs();
    for (int i = 0; i < 12; i++) cycle();
    vec++; if (acc_count != 4) begin errs++; $display("FAIL bp_accepted: got %0d tiles want 4", acc_count); end
    vec++; if (s_yrdy !== 1'b0) begin errs++; $display("FAIL bp_y_ready: got %0b want 0", s_yrdy); end
    vec++; if (cap_dat.size() != 0) begin errs++; $display("FAIL bp_no_output: got %0d pixels want 0", cap_dat.size()); end
    ready_en = 1'b1;
    px_ready = 1'b1;
    for (int i = 0; i < 100 && cap_dat.size() < 24; i++) cycle();
    vec++;
    if (cap_dat.size() != 24 || acc_cyc.size() != 6) begin
      errs++; $display("FAIL bp_drain: got %0d pixels %0d tiles want 24 pixels 6 tiles", cap_dat.size(), acc_cyc.size());
    end else begin
      vec++;
      if (acc_cyc[4] != cap_cyc[7] + 1) begin
        errs++; $display("FAIL bp_fifth_tile: accepted at cycle %0d want %0d", acc_cyc[4], cap_cyc[7] + 1);
      end
      for (int i = 0; i < 24; i++) begin
        vec++;
        if (cap_dat[i] !== W'(i + 1) || cap_eol[i] !== (i % 4 == 3) || cap_eof[i] !== (i == 15)) begin
          errs++; $display("FAIL bp_pixel[%0d]: got %0d eol %0b eof %0b want %0d eol %0b eof %0b",
                           i, cap_dat[i], cap_eol[i], cap_eof[i], i + 1, (i % 4 == 3), (i == 15));
        end
      end
    end
  endtask

  task automatic test_stall();
    bit           prev_stall;
    logic [W-1:0] p_dat;
    logic         p_eol, p_eof;
    do_reset();
    rnd_ready = 1'b1;
    push_frame(0);
    drive_inputs();
    prev_stall = 1'b0;
    p_dat = '0; p_eol = 1'b0; p_eof = 1'b0;
    for (int i = 0; i < 300 && cap_dat.size() < 16; i++) begin
      cycle();
      if (prev_stall) begin
        vec++;
        if (s_valid !== 1'b1 || s_dat !== p_dat || s_eol !== p_eol || s_eof !== p_eof) begin
          errs++; $display("FAIL stall_hold: got v%0b %0d eol %0b eof %0b want v1 %0d eol %0b eof %0b",
                           s_valid, s_dat, s_eol, s_eof, p_dat, p_eol, p_eof);
        end
      end
      prev_stall = s_valid && !s_pxr;
      p_dat = s_dat; p_eol = s_eol; p_eof = s_eof;
    end
    rnd_ready = 1'b0;
    vec++;
    if (cap_dat.size() != 16) begin
      errs++; $display("FAIL stall_count: got %0d pixels want 16", cap_dat.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        vec++;
        if (cap_dat[i] !== W'(i + 1) || cap_eol[i] !== (i % 4 == 3) || cap_eof[i] !== (i == 15)) begin
          errs++; $display("FAIL stall_pixel[%0d]: got %0d eol %0b eof %0b want %0d eol %0b eof %0b",
                           i, cap_dat[i], cap_eol[i], cap_eof[i], i + 1, (i % 4 == 3), (i == 15));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready_en = 1'b0;
    tile_q.push_back(tile(51, 52, 55, 56));
    tile_q.push_back(tile(53, 54, 57, 58));
    tile_q.push_back(tile(59, 60, 63, 64));
    drive_inputs();
    for (int i = 0; i < 20 && acc_count < 3; i++) cycle();
    vec++; if (acc_count != 3) begin errs++; $display("FAIL mid_preload: got %0d tiles want 3", acc_count); end
    rst = 1'b1;
    cycle();
    vec++; if (s_yrdy !== 1'b0) begin errs++; $display("FAIL mid_rst_y_ready: got %0b want 0", s_yrdy); end
    cycle();
    vec++; if (s_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_px_valid: got %0b want 0", s_valid); end
    vec++; if (s_yrdy !== 1'b0) begin errs++; $display("FAIL mid_rst_y_ready2: got %0b want 0", s_yrdy); end
    rst = 1'b0;
    clear_capture();
    ready_en = 1'b1;
    push_frame(0);
    drive_inputs();
    for (int i = 0; i < 60; i++) cycle();
    vec++;
    if (cap_dat.size() != 16) begin
      errs++; $display("FAIL mid_count: got %0d pixels want 16", cap_dat.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        vec++;
        if (cap_dat[i] !== W'(i + 1) || cap_eol[i] !== (i % 4 == 3) || cap_eof[i] !== (i == 15)) begin
          errs++; $display("FAIL mid_pixel[%0d]: got %0d eol %0b eof %0b want %0d eol %0b eof %0b",
                           i, cap_dat[i], cap_eol[i], cap_eof[i], i + 1, (i % 4 == 3), (i == 15));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready_en = 1'b1;
    push_frame(0);
    push_frame(16);
    drive_inputs();
    for (int i = 0; i < 100 && cap_dat.size() < 32; i++) cycle();
    vec++;
    if (cap_dat.size() != 32) begin
      errs++; $display("FAIL b2b_count: got %0d pixels want 32", cap_dat.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        vec++;
        if (cap_dat[i] !== W'(i + 1) || cap_eol[i] !== (i % 4 == 3) || cap_eof[i] !== (i == 15 || i == 31)
            || cap_cyc[i] != cap_cyc[0] + i) begin
          errs++; $display("FAIL b2b_pixel[%0d]: got %0d eol %0b eof %0b cyc %0d want %0d eol %0b eof %0b cyc %0d",
                           i, cap_dat[i], cap_eol[i], cap_eof[i], cap_cyc[i], i + 1, (i % 4 == 3),
                           (i == 15 || i == 31), cap_cyc[0] + i);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    y_valid   = 1'b0;
    y_data    = '0;
    px_ready  = 1'b0;
    ready_en  = 1'b0;
    rnd_ready = 1'b0;
    acc_count = 0;
    test_reset();
    test_single_row();
    test_full_frame();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
